uart_io_responder: RTL and testbench
====================================

// Module: uart_io_responder
// PURPOSE
//  Core-side responder for the CPU's UART request port (uart_size/uart_o_data/uart_write_flag/
//  uart_read_flag -> uart_i_data/uart_received). Serializes write words into bytes for a UART TX
//  byte engine. Assembles read words from a buffered UART RX byte stream. Sits between cpu and
//  the uart_tx/uart_rx PHYs.
// PARAMETERS
//  RX_FIFO_DEPTH  16  RX byte buffer entries; power of two, >=4
// PORTS
//  clk             in   1          system clock; one clock domain
//  rstn            in   1          reset, asynchronous, active-low
//  uart_size       in   2          bytes in transfer: 00=1, 01=2, 10=4, 11=4 (reserved, treated as 4)
//  uart_o_data     in   LEN_WORD   write word from core, LSB byte sent first
//  uart_write_flag in   1          write request, level, held by core until uart_received
//  uart_read_flag  in   1          read request, level, held by core until uart_received
//  uart_i_data     out  LEN_WORD   read result, little-endian, zero-extended
//  uart_received   out  1          1-cycle pulse: request complete
//  tx_data         out  8          byte to TX engine
//  tx_valid        out  1          tx_data valid
//  tx_ready        in   1          TX engine takes byte when tx_valid&tx_ready
//  rx_data         in   8          received byte
//  rx_valid        in   1          1-cycle strobe: rx_data valid
//  rx_overrun      out  1          sticky; set when a byte is dropped on full FIFO
// BEHAVIOUR
//  - Reset (rstn low, async): uart_i_data=0, uart_received=0, tx_data=0, tx_valid=0, rx_overrun=0.
//    FIFO is emptied, byte counters cleared, FSM goes to IDLE. A partial word is discarded and not
//    completed. Reset in TX_SEND drops tx_valid immediately.
//  - FSM: IDLE -> TX_SEND | RX_COLLECT -> DONE -> RELEASE -> IDLE.
//  - IDLE: samples the flags at an edge. write_flag has priority when both flags are high.
//    * Write: latches uart_o_data and the byte count N, then goes to TX_SEND.
//    * Read: clears the assembly register and goes to RX_COLLECT.
//  - TX_SEND: tx_valid=1 from the next cycle. tx_data = byte i (bits 8i+7:8i).
//    tx_data is held stable until the handshake. i advances on each handshake.
//    After handshake N-1: tx_valid=0, go to DONE.
//    With tx_ready=1 throughout, a request sampled at edge k gives bytes at k+1..k+N.
//  - RX_COLLECT: pops one byte per cycle while the FIFO is non-empty.
//    Byte j goes to bits 8j+7:8j; upper bits are 0.
//    Stalls with no timeout while the FIFO is empty.
//    After pop N-1, go to DONE.
//  - DONE: uart_received=1 for exactly this cycle. For a read, uart_i_data holds the assembled
//    word and keeps it until the next read completes.
//  - RELEASE: waits for both flags to be low, then goes to IDLE. A held flag is never re-serviced.
//  - Latency: sample at edge k; with data ready every cycle, uart_received is high in cycle k+N+1.
//  - RX FIFO (always active, independent of FSM):
//    * Push on rx_valid.
//    * Full with no pop: byte dropped, rx_overrun<=1. rx_overrun clears only on reset.
//    * Full with push and pop in the same cycle: both happen, no drop.
//    * Empty with push and pop in the same cycle: no bypass; the pop is deferred and the byte is
//      stored.
//    * Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty by MSB compare.
// STRUCTURE
//  - include.vh additions: UART_SIZE_B 2'b00, UART_SIZE_H 2'b01, UART_SIZE_W 2'b10; FSM state
//    one-hot defines (UIO_STATE_*).
//  - Sub-module byte_fifo (DEPTH param; push/pop/din/dout/full/empty; clk, async rstn).
//  - FSM and TX/RX byte counters live in this module.
// TESTING
//  1. Write 0xDEADBEEF, size=10, tx_ready=1 -> tx_data EF,BE,AD,DE in cycles k+1..k+4;
//     uart_received pulse in k+5.
//  2. Write size=00 data 0x00000041, tx_ready low 3 cycles -> tx_data 41 held stable with
//     tx_valid=1; one byte only; then a single pulse.
//  3. Pre-push RX 0x12,0x34,0x56,0x78, then read size=10 -> uart_i_data=0x78563412 with pulse at
//     k+5. Read size=01 on bytes AA,BB -> 0x0000BBAA.
//  4. Read size=10 with an empty FIFO, bytes arriving every 10 cycles -> no pulse until the 4th
//     byte; one pulse; flag held 5 extra cycles -> no second pulse.
//  5. Push DEPTH+1 bytes with no read -> rx_overrun=1; a later read returns the first bytes in
//     order; the last byte is lost.
//  6. Deassert rstn mid TX_SEND after byte 1 -> tx_valid=0 asynchronously; all outputs at reset
//     values; FIFO empty; a new write after reset starts from byte 0.

Source files
------------

// File: rtl/uart_io_responder_pkg.sv
// Shared types and constants for the CPU-side UART request responder.
// Word width, transfer-size encodings and the one-hot FSM state type.
package uart_io_responder_pkg;

  localparam int LEN_WORD = 32;

  localparam logic [1:0] UART_SIZE_B = 2'b00;
  localparam logic [1:0] UART_SIZE_H = 2'b01;
  localparam logic [1:0] UART_SIZE_W = 2'b10;

  localparam int UIO_IDLE_B = 0;
  localparam int UIO_TX_B   = 1;
  localparam int UIO_RX_B   = 2;
  localparam int UIO_DONE_B = 3;
  localparam int UIO_REL_B  = 4;

  typedef enum logic [4:0] {
    UIO_STATE_IDLE    = 5'b00001,
    UIO_STATE_TX_SEND = 5'b00010,
    UIO_STATE_RX_COLL = 5'b00100,
    UIO_STATE_DONE    = 5'b01000,
    UIO_STATE_RELEASE = 5'b10000
  } uio_state_e;

  // Index of the last byte in a transfer; reserved size 11 acts as a word.
  function automatic logic [1:0] size_last(input logic [1:0] sz);
    case (sz)
      UART_SIZE_B: return 2'd0;
      UART_SIZE_H: return 2'd1;
      default:     return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/uart_io_responder_if.sv
// CPU request port of the UART responder.
// master = core side, slave = responder side.
interface uart_io_responder_if;
  import uart_io_responder_pkg::*;

  logic [1:0]          uart_size;
  logic [LEN_WORD-1:0] uart_o_data;
  logic                uart_write_flag;
  logic                uart_read_flag;
  logic [LEN_WORD-1:0] uart_i_data;
  logic                uart_received;

  modport master (
    output uart_size,
    output uart_o_data,
    output uart_write_flag,
    output uart_read_flag,
    input  uart_i_data,
    input  uart_received
  );

  modport slave (
    input  uart_size,
    input  uart_o_data,
    input  uart_write_flag,
    input  uart_read_flag,
    output uart_i_data,
    output uart_received
  );

endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with extra-MSB pointers; read data is combinational.
// Push on full is accepted only when a pop frees a slot that cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_io_responder.sv
// Serializes core write words to a TX byte engine and assembles
// read words from a buffered RX byte stream.
module uart_io_responder
  import uart_io_responder_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_io_responder_if.slave   cpu,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_overrun
);

  uio_state_e          state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic [LEN_WORD-1:0] word_q, word_d;
  logic [LEN_WORD-1:0] asm_q, asm_d;
  logic [LEN_WORD-1:0] rdata_q, rdata_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rcv_q, rcv_d;
  logic                ovr_q, ovr_d;

  logic       pop;
  logic       drop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  byte_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop  = state_q[UIO_RX_B] && !fifo_empty;
  assign drop = rx_valid && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    word_d     = word_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rcv_d      = 1'b0;
    ovr_d      = ovr_q | drop;
    unique case (1'b1)
      state_q[UIO_IDLE_B]: begin
        idx_d  = 2'd0;
        last_d = size_last(cpu.uart_size);
        if (cpu.uart_write_flag) begin
          tx_data_d  = cpu.uart_o_data[7:0];
          word_d     = cpu.uart_o_data >> 8;
          tx_valid_d = 1'b1;
          state_d    = UIO_STATE_TX_SEND;
        end else if (cpu.uart_read_flag) begin
          asm_d   = '0;
          state_d = UIO_STATE_RX_COLL;
        end
      end
      state_q[UIO_TX_B]: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == last_q) begin
            tx_valid_d = 1'b0;
            rcv_d      = 1'b1;
            state_d    = UIO_STATE_DONE;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = word_q[7:0];
            word_d    = word_q >> 8;
          end
        end
      end
      state_q[UIO_RX_B]: begin
        if (pop) begin
          asm_d[{idx_q, 3'b000} +: 8] = fifo_dout;
          if (idx_q == last_q) begin
            rdata_d = asm_d;
            rcv_d   = 1'b1;
            state_d = UIO_STATE_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      state_q[UIO_DONE_B]: begin
        state_d = UIO_STATE_RELEASE;
      end
      state_q[UIO_REL_B]: begin
        // Held flags must drop before a new request is accepted.
        if (!cpu.uart_write_flag && !cpu.uart_read_flag)
          state_d = UIO_STATE_IDLE;
      end
      default: begin
        state_d    = UIO_STATE_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= UIO_STATE_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      word_q     <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rcv_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      word_q     <= word_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rcv_q      <= rcv_d;
      ovr_q      <= ovr_d;
    end
  end

  assign cpu.uart_i_data   = rdata_q;
  assign cpu.uart_received = rcv_q;
  assign tx_data           = tx_data_q;
  assign tx_valid          = tx_valid_q;
  assign rx_overrun        = ovr_q;

endmodule

// File: tb/tb_uart_io_responder.sv
// Directed bench for uart_io_responder: vector table plus
// hand-written stall, overrun and mid-transfer reset sequences.
module tb_uart_io_responder;
  import uart_io_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;

  uart_io_responder_if cpu ();

  uart_io_responder #(
    .RX_FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cpu        (cpu),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               rd;
    logic [1:0]       sz;
    logic [31:0]      d;
    int               n;
    logic [3:0][7:0]  b;
    logic [31:0]      w;
  } vec_t;

  vec_t tbl [9];
  int   ntot  = 0;
  int   npass = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [31:0] d,
                          input int n, input logic [3:0][7:0] eb,
                          input string nm);
    cpu.uart_size       = sz;
    cpu.uart_o_data     = d;
    cpu.uart_write_flag = 1'b1;
    tx_ready            = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s tx_valid[%0d]", nm, i), 32'(tx_valid), 32'd1);
      check($sformatf("%s tx_data[%0d]", nm, i), 32'(tx_data), 32'(eb[i]));
      check($sformatf("%s early_rcv[%0d]", nm, i),
            32'(cpu.uart_received), 32'd0);
    end
    step();
    check({nm, " rcv"}, 32'(cpu.uart_received), 32'd1);
    check({nm, " tx_valid_end"}, 32'(tx_valid), 32'd0);
    cpu.uart_write_flag = 1'b0;
    step();
    check({nm, " rcv_pulse"}, 32'(cpu.uart_received), 32'd0);
    step();
  endtask

  task automatic do_read(input logic [1:0] sz, input int n,
                         input logic [31:0] exp, input string nm);
    cpu.uart_size      = sz;
    cpu.uart_read_flag = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s early_rcv[%0d]", nm, i),
            32'(cpu.uart_received), 32'd0);
    end
    step();
    check({nm, " rcv"}, 32'(cpu.uart_received), 32'd1);
    check({nm, " i_data"}, cpu.uart_i_data, exp);
    cpu.uart_read_flag = 1'b0;
    step();
    check({nm, " rcv_pulse"}, 32'(cpu.uart_received), 32'd0);
    check({nm, " i_data_hold"}, cpu.uart_i_data, exp);
    step();
  endtask

  initial begin
    int          pulses;
    int          at;
    int          txv;
    logic [31:0] got;

    tbl[0] = '{1'b0, 2'b10, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 2'b00, 32'h00000041, 1, 32'h00000041, 32'h0};
    tbl[2] = '{1'b0, 2'b01, 32'h0000CAFE, 2, 32'h0000CAFE, 32'h0};
    tbl[3] = '{1'b0, 2'b11, 32'h12345678, 4, 32'h12345678, 32'h0};
    tbl[4] = '{1'b0, 2'b01, 32'hAABB1122, 2, 32'h00001122, 32'h0};
    tbl[5] = '{1'b1, 2'b10, 32'h0, 4, 32'h78563412, 32'h78563412};
    tbl[6] = '{1'b1, 2'b01, 32'h0, 2, 32'h0000BBAA, 32'h0000BBAA};
    tbl[7] = '{1'b1, 2'b00, 32'h0, 1, 32'h0000005A, 32'h0000005A};
    tbl[8] = '{1'b1, 2'b11, 32'h0, 4, 32'h04030201, 32'h04030201};

    rstn                = 1'b0;
    tx_ready            = 1'b0;
    rx_valid            = 1'b0;
    rx_data             = 8'h00;
    cpu.uart_size       = 2'b00;
    cpu.uart_o_data     = '0;
    cpu.uart_write_flag = 1'b0;
    cpu.uart_read_flag  = 1'b0;
    #12;
    check("rst i_data", cpu.uart_i_data, 32'h0);
    check("rst rcv", 32'(cpu.uart_received), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst overrun", 32'(rx_overrun), 32'd0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rd) begin
        for (int j = 0; j < tbl[i].n; j++) push(tbl[i].b[j]);
        do_read(tbl[i].sz, tbl[i].n, tbl[i].w, $sformatf("vec%0d", i));
      end else begin
        do_write(tbl[i].sz, tbl[i].d, tbl[i].n, tbl[i].b,
                 $sformatf("vec%0d", i));
      end
    end

    // Single byte write held against a stalled TX engine.
    tx_ready            = 1'b0;
    cpu.uart_size       = 2'b00;
    cpu.uart_o_data     = 32'h00000041;
    cpu.uart_write_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall tx_valid[%0d]", i), 32'(tx_valid), 32'd1);
      check($sformatf("stall tx_data[%0d]", i), 32'(tx_data), 32'h41);
      check($sformatf("stall rcv[%0d]", i), 32'(cpu.uart_received), 32'd0);
    end
    tx_ready = 1'b1;
    step();
    check("stall rcv", 32'(cpu.uart_received), 32'd1);
    check("stall tx_valid_end", 32'(tx_valid), 32'd0);
    pulses = 0;
    txv    = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cpu.uart_received) pulses++;
      if (tx_valid) txv++;
    end
    check("stall extra_pulses", 32'(pulses), 32'd0);
    check("stall extra_bytes", 32'(txv), 32'd0);
    cpu.uart_write_flag = 1'b0;
    step();
    step();

    // Read from an empty FIFO; bytes trickle in every 10 cycles.
    cpu.uart_size      = 2'b10;
    cpu.uart_read_flag = 1'b1;
    pulses = 0;
    at     = -1;
    got    = '0;
    for (int t = 0; t < 50; t++) begin
      rx_valid = (t == 5) || (t == 15) || (t == 25) || (t == 35);
      rx_data  = 8'(8'h11 * ((t / 10) + 1));
      step();
      if (cpu.uart_received) begin
        pulses++;
        at  = t;
        got = cpu.uart_i_data;
      end
    end
    rx_valid = 1'b0;
    check("slow pulses", 32'(pulses), 32'd1);
    check("slow pulse_cycle", 32'(at), 32'd36);
    check("slow i_data", got, 32'h44332211);
    cpu.uart_read_flag = 1'b0;
    step();
    step();

    // Overfill the FIFO by one byte.
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    check("ovr before", 32'(rx_overrun), 32'd0);
    push(8'h99);
    check("ovr after", 32'(rx_overrun), 32'd1);
    do_read(2'b10, 4, 32'h04030201, "ovr_w0");
    do_read(2'b10, 4, 32'h08070605, "ovr_w1");
    do_read(2'b10, 4, 32'h0C0B0A09, "ovr_w2");
    do_read(2'b10, 4, 32'h100F0E0D, "ovr_w3");
    push(8'hEE);
    do_read(2'b00, 1, 32'h000000EE, "ovr_lost");
    check("ovr sticky", 32'(rx_overrun), 32'd1);

    // Reset during TX_SEND with a byte left in the FIFO.
    push(8'h77);
    cpu.uart_size       = 2'b10;
    cpu.uart_o_data     = 32'hDEADBEEF;
    cpu.uart_write_flag = 1'b1;
    tx_ready            = 1'b1;
    step();
    check("mrst byte0", 32'(tx_data), 32'hEF);
    step();
    check("mrst byte1", 32'(tx_data), 32'hBE);
    #3;
    rstn = 1'b0;
    #1;
    check("mrst tx_valid", 32'(tx_valid), 32'd0);
    check("mrst tx_data", 32'(tx_data), 32'd0);
    check("mrst rcv", 32'(cpu.uart_received), 32'd0);
    check("mrst i_data", cpu.uart_i_data, 32'h0);
    check("mrst overrun", 32'(rx_overrun), 32'd0);
    cpu.uart_write_flag = 1'b0;
    step();
    rstn = 1'b1;
    step();
    check("mrst idle_tx_valid", 32'(tx_valid), 32'd0);
    push(8'h33);
    do_read(2'b00, 1, 32'h00000033, "mrst_fifo");
    do_write(2'b10, 32'hDEADBEEF, 4, 32'hDEADBEEF, "mrst_write");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
